idct_transpose_buf: RTL and testbench
=====================================

# idct_transpose_buf

Parametrised ping-pong transpose buffer between the row and column passes of the IDCT. It accepts one block of N×N row-pass results in row-major order and returns the same block transposed, i.e. column-major. Supported N is 4, 8, 16 or 32, capped by MAX_LOG2, and N is selected per block. Valid/ready handshakes on both sides allow stalls. Two banks let one block fill while the previous one drains, sustaining 1 sample/cycle.

## Interface
- WIDTH, 16: sample width, signed.
- MAX_LOG2, 4: log2 of the largest supported N; legal range 2..5. Each bank holds 2^(2·MAX_LOG2) words.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low; clock clk.
- in_valid  in  1  input sample valid.
- in_ready  out  1  buffer accepts a sample this cycle.
- in_data  in  WIDTH  input sample, row-major within the block.
- in_size  in  2  block size code, log2(N)−2; sampled only on the first sample of a block.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  WIDTH  transposed sample.
- out_size  out  2  size code of the block being output.
- out_last  out  1  final sample of the block.
- size_err  out  1  sticky flag: an illegal size code was seen (code > MAX_LOG2−2).

## Operation
- Transfers happen only on valid&ready. in_data/in_size are held stable by upstream while in_valid=1 and in_ready=0; the block holds out_* stable while out_valid=1 and out_ready=0.
- Each bank has four states: EMPTY, FILL, FULL, DRAIN. wr_bank and rd_bank pointers both start at bank 0.
- in_ready=1 iff bank[wr_bank] is EMPTY or in FILL.
  - First accepted sample: latch size into bank_size[wr_bank]; bank enters FILL.
- Write addressing: input index k=r·N+c (r = row, c = column) is stored at address c·N+r. This uses a row/column counter pair, not a multiplier, and the counters wrap at N.
- After sample N²−1 is accepted, the bank goes FULL and wr_bank toggles.
- Read side:
  - When bank[rd_bank] is FULL it enters DRAIN and reads addresses 0..N²−1 sequentially.
  - A read is issued only if the 2-entry output FIFO has a free slot after counting the read already in flight.
  - Issuing the final read returns the bank to EMPTY and toggles rd_bank.
- out_size and out_last travel with each read through the pipeline. out_last is set on the read of address N²−1.
- Illegal size code: the block is processed as N=2^MAX_LOG2 and size_err is set; only rst_n clears it.
- Each block uses only the low N² words of its bank. Stale contents are never read.

## Timing
- Reset values: in_ready=0 while rst_n=0, then 1 on the first cycle after reset. out_valid=0, out_data=0, out_size=0, out_last=0, size_err=0, both banks EMPTY, all counters 0.
- Memory read latency is 1 cycle and is registered into the output FIFO.
- Latency: the last input accepted at edge E yields the first out_valid=1 after edge E+2, provided rd_bank had nothing ahead of it.
- Throughput: with out_ready held at 1 and blocks back-to-back, in_ready never drops and out_valid is continuous from the first block's output onward.
- Both banks FULL or draining: in_ready=0 until the draining bank issues its final read. A write into that bank is then accepted on the next cycle.
- Simultaneous final read and first write to the same bank are not possible. The bank becomes EMPTY at the edge of its final read, and the write lands one or more cycles later.
- out_ready=0 stalls reads within 1 cycle. The FIFO absorbs the in-flight read, so nothing is lost or duplicated.
- rst_n mid-block discards partial and stored blocks. Nothing is output for them.

## Structure
- Package idct_pkg:
  - size-code type (2 bits) and constants SZ4=0, SZ8=1, SZ16=2, SZ32=3;
  - function size_to_n(code);
  - bank-state enum {EMPTY, FILL, FULL, DRAIN}.
- Sub-module tp_bank_ram: simple dual-port RAM with synchronous read, WIDTH × 2^(2·MAX_LOG2). Instantiated twice.
- The output FIFO (2 entries) is kept inline.

## Test plan
- Reset, then one 4×4 block, in_data 0..15, size 0, out_ready=1 → outputs 0,4,8,12,1,5,9,13,…,15. out_last only on 15; out_size=0; first out_valid 2 cycles after the last input.
- Three back-to-back 8×8 blocks, data 0..63 per block → output k equals (k mod 8)·8+⌊k/8⌋ for each block. in_ready stays 1 throughout; output is gap-free after the first block.
- 16×16 block with out_ready toggling in a 1-0-1-1-0 pattern → all 256 samples in transposed order, no drops or repeats. in_ready drops to 0 once both banks are occupied.
- Mixed sizes: 4×4 block, then 8×8, then 4×4 → each block is transposed with its own out_size (0,1,0). out_last lands at sample 15, 63 and 15.
- Illegal size code 3 with MAX_LOG2=4 → size_err=1; the block is handled as 16×16. size_err stays 1 until rst_n.
- rst_n pulse after 40 samples of an 8×8 block, then a fresh 4×4 block → no output from the partial block; the 4×4 block is output correctly.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared types for the IDCT transpose buffer: block size codes and bank states.
package idct_pkg;

  typedef logic [1:0] size_code_t;

  localparam size_code_t SZ4  = 2'd0;
  localparam size_code_t SZ8  = 2'd1;
  localparam size_code_t SZ16 = 2'd2;
  localparam size_code_t SZ32 = 2'd3;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL,
    DRAIN
  } bank_state_e;

  function automatic logic [5:0] size_to_n(input size_code_t code);
    return 6'd4 << code;
  endfunction

endpackage

// File: rtl/tp_bank_ram.sv
// Simple dual-port bank RAM: one write port, one synchronous read port.
module tp_bank_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong N x N transpose buffer between IDCT row and column passes.
// Bank state | meaning
// EMPTY      | free, next write starts a block and latches its size
// FILL       | partially written
// FULL       | complete block waiting for the read side
// DRAIN      | being read out in address order
module idct_transpose_buf
  import idct_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_size,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_size,
  output logic             out_last,
  output logic             size_err
);

  localparam int AW = 2 * MAX_LOG2;
  localparam int CW = MAX_LOG2;
  localparam size_code_t MAX_CODE = size_code_t'(MAX_LOG2 - 2);

  function automatic logic [CW-1:0] n_minus1(input size_code_t c);
    return CW'(size_to_n(c) - 6'd1);
  endfunction

  function automatic logic [AW-1:0] last_addr(input size_code_t c);
    return (AW'(n_minus1(c)) << (32'(c) + 2)) | AW'(n_minus1(c));
  endfunction

  bank_state_e      bank_state_q [2], bank_state_d [2];
  size_code_t       bank_size_q  [2], bank_size_d  [2];
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [CW-1:0]    row_q, row_d, col_q, col_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic             size_err_q, size_err_d;
  logic             pend_q, pend_d, pend_bank_q, pend_bank_d, pend_last_q, pend_last_d;
  size_code_t       pend_size_q, pend_size_d;
  logic [WIDTH-1:0] fifo_data_q [2], fifo_data_d [2];
  size_code_t       fifo_size_q [2], fifo_size_d [2];
  logic [1:0]       fifo_last_q, fifo_last_d;
  logic             fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;

  logic             wr_first, in_illegal, accept_in, wr_last, wr_col_last;
  size_code_t       in_code, wr_code;
  logic [CW-1:0]    wr_nm1;
  logic [AW-1:0]    wr_addr;
  logic             rd_avail, rd_last, rd_issue, fifo_push, fifo_pop;
  logic [2:0]       fifo_occ;
  logic [WIDTH-1:0] ram_rdata [2];

  assign wr_first    = (bank_state_q[wr_bank_q] == EMPTY);
  assign in_ready    = rst_n && (wr_first || bank_state_q[wr_bank_q] == FILL);
  assign accept_in   = in_valid && in_ready;
  assign in_illegal  = (in_size > MAX_CODE);
  assign in_code     = in_illegal ? MAX_CODE : in_size;
  assign wr_code     = wr_first ? in_code : bank_size_q[wr_bank_q];
  assign wr_nm1      = n_minus1(wr_code);
  assign wr_col_last = (col_q == wr_nm1);
  assign wr_last     = wr_col_last && (row_q == wr_nm1);
  // Transposing store: row-major index r*N+c lands at c*N+r
  assign wr_addr     = (AW'(col_q) << (32'(wr_code) + 2)) | AW'(row_q);

  // Free-slot check counts the read already in flight and this cycle's pop
  assign fifo_pop  = (fifo_cnt_q != 2'd0) && out_ready;
  assign fifo_push = pend_q;
  assign fifo_occ  = 3'(fifo_cnt_q) + 3'(pend_q) - 3'(fifo_pop);
  assign rd_avail  = (bank_state_q[rd_bank_q] == FULL) || (bank_state_q[rd_bank_q] == DRAIN);
  assign rd_issue  = rd_avail && (fifo_occ < 3'd2);
  assign rd_last   = (rd_addr_q == last_addr(bank_size_q[rd_bank_q]));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tp_bank_ram #(.WIDTH(WIDTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (accept_in && (wr_bank_q == 1'(b))),
      .waddr (wr_addr),
      .wdata (in_data),
      .re    (rd_issue && (rd_bank_q == 1'(b))),
      .raddr (rd_addr_q),
      .rdata (ram_rdata[b])
    );
  end

  always_comb begin
    bank_state_d = bank_state_q;
    bank_size_d  = bank_size_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    row_d        = row_q;
    col_d        = col_q;
    rd_addr_d    = rd_addr_q;
    size_err_d   = size_err_q;
    pend_d       = rd_issue;
    pend_bank_d  = rd_bank_q;
    pend_size_d  = bank_size_q[rd_bank_q];
    pend_last_d  = rd_last;
    fifo_data_d  = fifo_data_q;
    fifo_size_d  = fifo_size_q;
    fifo_last_d  = fifo_last_q;
    fifo_wp_d    = fifo_wp_q;
    fifo_rp_d    = fifo_rp_q;

    if (accept_in) begin
      if (wr_first) begin
        bank_size_d[wr_bank_q]  = in_code;
        bank_state_d[wr_bank_q] = FILL;
        size_err_d              = size_err_q || in_illegal;
      end
      if (wr_last) begin
        bank_state_d[wr_bank_q] = FULL;
        wr_bank_d               = !wr_bank_q;
        row_d                   = '0;
        col_d                   = '0;
      end else if (wr_col_last) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // Read and write sides never act on the same bank in one cycle
    if (rd_issue) begin
      if (rd_last) begin
        bank_state_d[rd_bank_q] = EMPTY;
        rd_bank_d               = !rd_bank_q;
        rd_addr_d               = '0;
      end else begin
        bank_state_d[rd_bank_q] = DRAIN;
        rd_addr_d               = rd_addr_q + 1'b1;
      end
    end

    if (fifo_push) begin
      fifo_data_d[fifo_wp_q] = ram_rdata[pend_bank_q];
      fifo_size_d[fifo_wp_q] = pend_size_q;
      fifo_last_d[fifo_wp_q] = pend_last_q;
      fifo_wp_d              = !fifo_wp_q;
    end
    if (fifo_pop) fifo_rp_d = !fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q + 2'(fifo_push) - 2'(fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_state_q <= '{EMPTY, EMPTY};
      bank_size_q  <= '{SZ4, SZ4};
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      rd_addr_q    <= '0;
      size_err_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_bank_q  <= 1'b0;
      pend_size_q  <= SZ4;
      pend_last_q  <= 1'b0;
      fifo_data_q  <= '{default: '0};
      fifo_size_q  <= '{SZ4, SZ4};
      fifo_last_q  <= '0;
      fifo_wp_q    <= 1'b0;
      fifo_rp_q    <= 1'b0;
      fifo_cnt_q   <= '0;
    end else begin
      bank_state_q <= bank_state_d;
      bank_size_q  <= bank_size_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      row_q        <= row_d;
      col_q        <= col_d;
      rd_addr_q    <= rd_addr_d;
      size_err_q   <= size_err_d;
      pend_q       <= pend_d;
      pend_bank_q  <= pend_bank_d;
      pend_size_q  <= pend_size_d;
      pend_last_q  <= pend_last_d;
      fifo_data_q  <= fifo_data_d;
      fifo_size_q  <= fifo_size_d;
      fifo_last_q  <= fifo_last_d;
      fifo_wp_q    <= fifo_wp_d;
      fifo_rp_q    <= fifo_rp_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo_data_q[fifo_rp_q];
  assign out_size  = fifo_size_q[fifo_rp_q];
  assign out_last  = fifo_last_q[fifo_rp_q];
  assign size_err  = size_err_q;

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Directed bench for idct_transpose_buf: transpose order, sizes, stalls, reset.
module tb_idct_transpose_buf;

  localparam int WIDTH    = 16;
  localparam int MAX_LOG2 = 4;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [WIDTH-1:0] in_data = '0, out_data;
  logic [1:0]       in_size = '0, out_size;
  logic             out_valid, out_ready = 1'b1, out_last, size_err;

  typedef struct {int data; int size; bit last;} exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_err = 0, cyc = 0;
  int last_acc_edge = 0, first_cyc = 0, stalls = 0, gaps = 0;
  bit seen_first = 0, toggle_rdy = 0;

  idct_transpose_buf #(.WIDTH(WIDTH), .MAX_LOG2(MAX_LOG2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_size   (in_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_size  (out_size),
    .out_last  (out_last),
    .size_err  (size_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output side: drives out_ready and scores every accepted sample
  initial begin
    int pidx;
    logic [4:0] pat;
    pidx = 0;
    pat  = 5'b01101;  // 1,0,1,1,0 starting at bit 0
    forever begin
      @(negedge clk);
      if (toggle_rdy) begin
        out_ready = pat[pidx];
        pidx = (pidx + 1) % 5;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && !seen_first) begin
        seen_first = 1;
        first_cyc  = cyc;
      end
      if (!out_valid && seen_first && exp_q.size() > 0) gaps++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_size", 32'(out_size), 32'(e.size));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  task automatic send_sample(input int d, input int code);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = WIDTH'(d);
    in_size  = 2'(code);
    #1;
    w = 0;
    while (!in_ready && w < 3000) begin
      stalls++;
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 3000) chk("in_ready_timeout", 32'(in_ready), 1);
    last_acc_edge = cyc + 1;
  endtask

  task automatic send_block(input int base, input int code);
    int eff, n;
    exp_t e;
    eff = (code > MAX_LOG2 - 2) ? MAX_LOG2 - 2 : code;
    n   = 4 << eff;
    for (int k = 0; k < n * n; k++) begin
      e.data = base + (k % n) * n + k / n;
      e.size = eff;
      e.last = (k == n * n - 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < n * n; i++) send_sample(base + i, code);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic start_test();
    seen_first = 0;
    gaps       = 0;
    stalls     = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_size", 32'(out_size), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_size_err", 32'(size_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(in_ready), 1);

    // single 4x4 block, latency from last input to first output
    start_test();
    send_block(0, 0);
    idle();
    drain();
    chk("latency_4x4", 32'(first_cyc - last_acc_edge), 2);

    // three back-to-back 8x8 blocks at full rate
    start_test();
    for (int b = 0; b < 3; b++) send_block(0, 1);
    idle();
    drain();
    chk("b2b_in_stalls", 32'(stalls), 0);
    chk("b2b_out_gaps", 32'(gaps), 0);

    // 16x16 blocks with a stalling consumer
    start_test();
    toggle_rdy = 1;
    for (int b = 0; b < 3; b++) send_block(b * 300, 2);
    idle();
    drain();
    toggle_rdy = 0;
    chk("stall_in_ready_drop", 32'(stalls > 0), 1);

    // mixed sizes
    start_test();
    send_block(0, 0);
    send_block(16, 1);
    send_block(80, 0);
    idle();
    drain();

    // illegal size code, handled as 16x16, sticky error
    start_test();
    chk("size_err_before", 32'(size_err), 0);
    send_block(1000, 3);
    idle();
    drain();
    chk("size_err_set", 32'(size_err), 1);
    send_block(2000, 0);
    idle();
    drain();
    chk("size_err_sticky", 32'(size_err), 1);

    // reset part-way through an 8x8 block
    start_test();
    for (int i = 0; i < 40; i++) send_sample(3000 + i, 1);
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_size_err", 32'(size_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_block(500, 0);
    idle();
    drain();
    chk("post_rst_size_err", 32'(size_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
